// File: rtl/q_proj_pkg.sv
// Shared widths, FSM state type and tile payload for the Q-projection tile sequencer.
package q_proj_pkg;

  localparam int unsigned N          = 4;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ACC_WIDTH  = 32;

  localparam int unsigned TILE_W  = N * N * DATA_WIDTH;
  localparam int unsigned BIAS_W  = N * ACC_WIDTH;
  localparam int unsigned RES_W   = N * N * ACC_WIDTH;
  localparam int unsigned TIMER_W = 16;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIAS,
    ST_LOAD,
    ST_COMPUTE,
    ST_DONE,
    ST_WAIT_V,
    ST_OUT
  } seq_state_t;

  typedef struct packed {
    logic [TILE_W-1:0] a;
    logic [TILE_W-1:0] b;
    logic [BIAS_W-1:0] bias;
  } tile_pkt_t;

endpackage

// File: rtl/q_seq_timer.sv
// Loadable down-counter with a registered zero flag; stops at zero.
module q_seq_timer
  import q_proj_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_val;
      zero  <= (load_val == '0);
    end else if (dec && !zero) begin
      count <= count - TIMER_W'(1);
      zero  <= (count == TIMER_W'(1));
    end
  end

endmodule

// File: rtl/q_tile_sequencer.sv
// Sequences bias load, tile write and tile-done strobes for Black_Box and returns its result.
// Define Q_SEQ_KACC_EN for K-group accumulation (bias on first tile, result on last tile only).
module q_tile_sequencer
  import q_proj_pkg::*;
#(
  parameter int unsigned COMPUTE_CYCLES = 12,
  parameter int unsigned VALID_TIMEOUT  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [TILE_W-1:0]  s_a,
  input  logic [TILE_W-1:0]  s_b,
  input  logic [BIAS_W-1:0]  s_bias,
  input  logic               s_first,
  input  logic               s_last,
  output logic               bb_load_bias,
  output logic [BIAS_W-1:0]  bb_bias,
  output logic [TILE_W-1:0]  bb_matrix_a,
  output logic [TILE_W-1:0]  bb_matrix_b,
  output logic               bb_write_en,
  output logic               bb_tile_done,
  input  logic [RES_W-1:0]   bb_matrix_c,
  input  logic               bb_valid,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [RES_W-1:0]   m_data,
  output logic [COUNT_W-1:0] tile_count,
  output logic               err_timeout
);

  seq_state_t state, state_n;
  tile_pkt_t  tile_q;

  logic cmp_load, cmp_dec, cmp_zero;
  logic to_load, to_dec, to_zero;
  logic capture_tile, capture_res, count_inc, set_err;

`ifdef Q_SEQ_KACC_EN
  logic kacc_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kacc_last_q <= 1'b0;
    end else if (capture_tile) begin
      kacc_last_q <= s_last;
    end
  end
`else
  logic unused_kacc;
  assign unused_kacc = s_first ^ s_last;
`endif

  // COMPUTE lasts COMPUTE_CYCLES-1 cycles so tile_done lands COMPUTE_CYCLES after write_en
  q_seq_timer u_compute_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (cmp_load),
    .load_val (TIMER_W'(COMPUTE_CYCLES - 2)),
    .dec      (cmp_dec),
    .zero     (cmp_zero)
  );

  // WAIT_V window closes so err_timeout rises VALID_TIMEOUT cycles after tile_done
  q_seq_timer u_valid_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (TIMER_W'(VALID_TIMEOUT - 2)),
    .dec      (to_dec),
    .zero     (to_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    cmp_load     = 1'b0;
    cmp_dec      = 1'b0;
    to_load      = 1'b0;
    to_dec       = 1'b0;
    capture_tile = 1'b0;
    capture_res  = 1'b0;
    count_inc    = 1'b0;
    set_err      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_valid && s_ready) begin
          capture_tile = 1'b1;
`ifdef Q_SEQ_KACC_EN
          state_n = s_first ? ST_BIAS : ST_LOAD;
`else
          state_n = ST_BIAS;
`endif
        end
      end
      ST_BIAS: state_n = ST_LOAD;
      ST_LOAD: begin
        cmp_load = 1'b1;
        state_n  = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (cmp_zero) begin
`ifdef Q_SEQ_KACC_EN
          state_n = kacc_last_q ? ST_DONE : ST_IDLE;
`else
          state_n = ST_DONE;
`endif
        end else begin
          cmp_dec = 1'b1;
        end
      end
      ST_DONE: begin
        to_load = 1'b1;
        state_n = ST_WAIT_V;
      end
      ST_WAIT_V: begin
        if (bb_valid) begin
          capture_res = 1'b1;
          state_n     = ST_OUT;
        end else if (to_zero) begin
          set_err = 1'b1;
          state_n = ST_IDLE;
        end else begin
          to_dec = 1'b1;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          count_inc = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Strobes and handshakes are registered decodes of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready      <= 1'b0;
      bb_load_bias <= 1'b0;
      bb_write_en  <= 1'b0;
      bb_tile_done <= 1'b0;
      m_valid      <= 1'b0;
      tile_q       <= '0;
      m_data       <= '0;
      tile_count   <= '0;
      err_timeout  <= 1'b0;
    end else begin
      s_ready      <= (state_n == ST_IDLE);
      bb_load_bias <= (state_n == ST_BIAS);
      bb_write_en  <= (state_n == ST_LOAD);
      bb_tile_done <= (state_n == ST_DONE);
      m_valid      <= (state_n == ST_OUT);
      if (capture_tile) begin
        tile_q <= '{a: s_a, b: s_b, bias: s_bias};
      end
      if (capture_res) begin
        m_data <= bb_matrix_c;
      end
      if (count_inc) begin
        tile_count <= tile_count + COUNT_W'(1);
      end
      if (set_err) begin
        err_timeout <= 1'b1;
      end
    end
  end

  assign bb_matrix_a = tile_q.a;
  assign bb_matrix_b = tile_q.b;
  assign bb_bias     = tile_q.bias;

endmodule

// File: tb/tb_q_tile_sequencer.sv
// Randomized self-checking bench for q_tile_sequencer; honours Q_SEQ_KACC_EN when defined.
module tb_q_tile_sequencer;
  import q_proj_pkg::*;

  localparam int unsigned CC = 12;
  localparam int unsigned VT = 8;
`ifdef Q_SEQ_KACC_EN
  localparam bit KACC = 1'b1;
`else
  localparam bit KACC = 1'b0;
`endif

  logic               clk, rst;
  logic               s_valid, s_ready, s_first, s_last;
  logic [TILE_W-1:0]  s_a, s_b, bb_matrix_a, bb_matrix_b;
  logic [BIAS_W-1:0]  s_bias, bb_bias;
  logic               bb_load_bias, bb_write_en, bb_tile_done, bb_valid;
  logic [RES_W-1:0]   bb_matrix_c, m_data;
  logic               m_valid, m_ready, err_timeout;
  logic [COUNT_W-1:0] tile_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [COUNT_W-1:0] cnt_exp;
  bit err_exp;

  q_tile_sequencer #(.COMPUTE_CYCLES(CC), .VALID_TIMEOUT(VT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_bias(s_bias),
    .s_first(s_first), .s_last(s_last),
    .bb_load_bias(bb_load_bias), .bb_bias(bb_bias),
    .bb_matrix_a(bb_matrix_a), .bb_matrix_b(bb_matrix_b),
    .bb_write_en(bb_write_en), .bb_tile_done(bb_tile_done),
    .bb_matrix_c(bb_matrix_c), .bb_valid(bb_valid),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .tile_count(tile_count), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RES_W-1:0] got, input logic [RES_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TILE_W-1:0] rand_tile();
    logic [TILE_W-1:0] v;
    for (int i = 0; i < int'(TILE_W / 32); i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [RES_W-1:0] rand_res();
    logic [RES_W-1:0] v;
    for (int i = 0; i < int'(RES_W / 32); i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Hold reset n cycles (s_valid high throughout); all outputs must read zero
  task automatic apply_reset(input int n);
    rst      = 1'b1;
    s_valid  = 1'b1;
    bb_valid = 1'b0;
    m_ready  = 1'b0;
    cnt_exp  = '0;
    err_exp  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_ctl", RES_W'({s_ready, bb_load_bias, bb_write_en, bb_tile_done, m_valid, err_timeout}), '0);
      chk("rst_bus", RES_W'({bb_matrix_a, bb_matrix_b, bb_bias}), '0);
      chk("rst_mdata", m_data, '0);
      chk("rst_count", RES_W'(tile_count), '0);
    end
    rst     = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", RES_W'(s_ready), RES_W'(1'b1));
  endtask

  // One tile: dly = cycles from tile_done to the bb_valid pulse (0 = never),
  // bp = m_ready backpressure cycles, gap = idle cycles before, abort_k = reset at that cycle
  task automatic run_tile(input logic [TILE_W-1:0] a, input logic [TILE_W-1:0] b,
                          input logic [BIAS_W-1:0] bias, input logic [RES_W-1:0] c,
                          input bit first, input bit last,
                          input int dly, input int bp, input int gap, input int abort_k);
    bit do_bias, do_done, ok_res;
    int wk, dk, mk, kend;
    logic [2:0] exp_s;
    do_bias = !KACC || first;
    do_done = !KACC || last;
    ok_res  = do_done && dly >= 1 && dly <= int'(VT) - 1;
    wk      = do_bias ? 2 : 1;
    dk      = wk + int'(CC);
    mk      = dk + dly + 1;
    if (ok_res)       kend = mk + bp + 1;
    else if (do_done) kend = dk + int'(VT);
    else              kend = dk;

    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("idle_ready", RES_W'(s_ready), RES_W'(1'b1));
      chk("idle_strobes", RES_W'({bb_load_bias, bb_write_en, bb_tile_done, m_valid}), '0);
    end
    @(negedge clk);
    chk("hs_ready", RES_W'(s_ready), RES_W'(1'b1));
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    s_bias  = bias;
    s_first = first;
    s_last  = last;

    for (int k = 1; k <= kend; k++) begin
      @(negedge clk);
      if (k == 1) begin
        s_valid = 1'b0;
        s_a     = rand_tile();
        s_b     = rand_tile();
        s_bias  = rand_tile();
        s_first = 1'($urandom_range(0, 1));
        s_last  = 1'($urandom_range(0, 1));
      end
      if (k == kend) begin
        if (ok_res) cnt_exp = cnt_exp + COUNT_W'(1);
        if (do_done && !ok_res) err_exp = 1'b1;
      end
      exp_s = {k == 1 && do_bias, k == wk, do_done && k == dk};
      chk("strobes", RES_W'({bb_load_bias, bb_write_en, bb_tile_done}), RES_W'(exp_s));
      chk("s_ready", RES_W'(s_ready), RES_W'(k == kend));
      chk("m_valid", RES_W'(m_valid), RES_W'(ok_res && k >= mk && k < kend));
      if (ok_res && k >= mk && k < kend) chk("m_data", m_data, c);
      chk("tile_count", RES_W'(tile_count), RES_W'(cnt_exp));
      chk("err_timeout", RES_W'(err_timeout), RES_W'(err_exp));
      chk("bb_bus", RES_W'({bb_matrix_a, bb_matrix_b, bb_bias}), RES_W'({a, b, bias}));
      if (k == abort_k) begin
        apply_reset(2);
        return;
      end
      // bb_valid noise up to tile_done must be ignored; the real pulse follows later
      bb_valid    = (dly != 0 && k == dk + dly) || (k <= dk && $urandom_range(0, 3) == 0);
      bb_matrix_c = (dly != 0 && k == dk + dly) ? c : rand_res();
      if (k < mk) m_ready = 1'($urandom_range(0, 1));
      else        m_ready = (k == mk + bp);
    end
    bb_valid = 1'b0;
    m_ready  = 1'b0;
  endtask

  logic [TILE_W-1:0] a0, b0;
  logic [BIAS_W-1:0] bias0;
  logic [RES_W-1:0]  c0;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
    s_a = '0; s_b = '0; s_bias = '0; bb_valid = 1'b0; bb_matrix_c = '0; m_ready = 1'b0;
    a0    = 128'h0102030405060708090a0b0c0d0e0f10;
    b0    = 128'h1112131415161718191a1b1c1d1e1f20;
    bias0 = {4{32'h0000_0001}};
    c0    = {64{8'hA5}};

    apply_reset(3);
    run_tile(a0, b0, bias0, c0, 1'b1, 1'b1, 1, 0, 0, 0);
    run_tile(rand_tile(), rand_tile(), rand_tile(), rand_res(), 1'b1, 1'b1, 1, 5, 1, 0);
    run_tile(rand_tile(), rand_tile(), rand_tile(), rand_res(), 1'b1, 1'b1, 0, 0, 0, 0);
    run_tile(rand_tile(), rand_tile(), rand_tile(), rand_res(), 1'b1, 1'b1, int'(VT) - 1, 2, 0, 0);
    run_tile(rand_tile(), rand_tile(), rand_tile(), rand_res(), 1'b1, 1'b0, 1, 0, 0, 0);
    run_tile(rand_tile(), rand_tile(), rand_tile(), rand_res(), 1'b0, 1'b0, 1, 0, 0, 0);
    run_tile(rand_tile(), rand_tile(), rand_tile(), rand_res(), 1'b0, 1'b1, 1, 0, 0, 0);
    run_tile(a0, b0, bias0, c0, 1'b1, 1'b1, 1, 0, 0, 8);
    run_tile(a0, b0, bias0, c0, 1'b1, 1'b1, 1, 0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      int dly, bp, gap, ab;
      bit f, l;
      f   = 1'($urandom_range(0, 1));
      l   = 1'($urandom_range(0, 1));
      dly = ($urandom_range(0, 9) < 2) ? 0 : int'($urandom_range(1, VT - 1));
      bp  = int'($urandom_range(0, 4));
      gap = int'($urandom_range(0, 3));
      ab  = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 12)) : 0;
      run_tile(rand_tile(), rand_tile(), rand_tile(), rand_res(), f, l, dly, bp, gap, ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
